// File: rtl/conv_encoder_kparam_if.sv
// Stream bundle for the convolutional encoder: bit input side and symbol
// output side, each with a valid/ready handshake.
//   in_valid/in_ready/in_bit/in_last       : unencoded bit stream
//   out_valid/out_ready/out_sym/out_last   : encoded {sym1,sym0} stream
// master = bit source / symbol sink, slave = encoder.
interface conv_encoder_kparam_if;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sym;
  logic       out_last;

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_sym, out_last
  );

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_sym, out_last
  );
endinterface

// File: rtl/conv_encoder_kparam.sv
// Rate-1/2 feed-forward convolutional encoder with runtime constraint length
// (3..K_MAX) and runtime generators, frame handling with automatic zero-tail
// termination (K-1 flush symbols) and a one-stage output register.
// Ports:
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   k_sel_i             : constraint length, clamped to 3..K_MAX, sampled at frame start
//   g0_i / g1_i         : generators for sym1 / sym0, sampled at frame start
//   bus (slave)         : input bit stream and output symbol stream
//   busy_o              : frame in progress (DATA or TAIL)
//   frame_cnt_o         : completed-frame count (only with STATS_EN defined)
// Optional feature macro: STATS_EN.
module conv_encoder_kparam #(
  parameter int unsigned K_MAX = 7,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [3:0]           k_sel_i,
  input  logic [K_MAX-1:0]     g0_i,
  input  logic [K_MAX-1:0]     g1_i,
  conv_encoder_kparam_if.slave bus,
  output logic                 busy_o
`ifdef STATS_EN
  ,
  output logic [CNT_W-1:0]     frame_cnt_o
`endif
);

  localparam int unsigned H_W = K_MAX - 1;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TAIL} state_e;

  state_e           state_q, state_d;
  logic [H_W-1:0]   hist_q, hist_d;
  logic [3:0]       k_q, k_d;
  logic [K_MAX-1:0] g0_q, g0_d, g1_q, g1_d;
  logic [3:0]       tail_q, tail_d;
  logic             out_valid_q, out_valid_d;
  logic [1:0]       out_sym_q, out_sym_d;
  logic             out_last_q, out_last_d;
  logic             busy_q, busy_d;

  logic             slot_free_c, in_ready_c, accept_c, tail_step_c, u_c;
  logic [3:0]       k_eff_c;
  logic [K_MAX-1:0] g0_eff_c, g1_eff_c, mask_c, taps_c;
  logic [1:0]       sym_c;

  // Clamp the requested constraint length into 3..K_MAX.
  function automatic logic [3:0] clamp_k(input logic [3:0] k);
    if (k < 4'd3)                  return 4'd3;
    else if (32'(k) > K_MAX)       return 4'(K_MAX);
    else                           return k;
  endfunction

  // Handshake, tap selection and symbol computation.
  always_comb begin
    slot_free_c = !out_valid_q || bus.out_ready;
    in_ready_c  = (state_q != S_TAIL) && slot_free_c;
    accept_c    = bus.in_valid && in_ready_c;
    tail_step_c = (state_q == S_TAIL) && slot_free_c;
    // In IDLE the first bit is encoded with the configuration being latched.
    k_eff_c     = (state_q == S_IDLE) ? clamp_k(k_sel_i) : k_q;
    g0_eff_c    = (state_q == S_IDLE) ? g0_i : g0_q;
    g1_eff_c    = (state_q == S_IDLE) ? g1_i : g1_q;
    mask_c      = '0;
    for (int j = 0; j < int'(K_MAX); j++) begin
      mask_c[j] = (j < int'(k_eff_c));
    end
    u_c    = (state_q == S_TAIL) ? 1'b0 : bus.in_bit;
    taps_c = {hist_q, u_c};
    sym_c  = {^(taps_c & g0_eff_c & mask_c), ^(taps_c & g1_eff_c & mask_c)};
  end

  // Next-state and register inputs.
  always_comb begin
    state_d     = state_q;
    hist_d      = hist_q;
    k_d         = k_q;
    g0_d        = g0_q;
    g1_d        = g1_q;
    tail_d      = tail_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_sym_d   = out_sym_q;
    out_last_d  = out_last_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          k_d     = k_eff_c;
          g0_d    = g0_i;
          g1_d    = g1_i;
          state_d = bus.in_last ? S_TAIL : S_DATA;
          tail_d  = 4'(k_eff_c - 4'd1);
        end
      end
      S_DATA: begin
        if (accept_c && bus.in_last) begin
          state_d = S_TAIL;
          tail_d  = 4'(k_eff_c - 4'd1);
        end
      end
      S_TAIL: begin
        if (tail_step_c) begin
          tail_d = 4'(tail_q - 4'd1);
          if (tail_q == 4'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (accept_c || tail_step_c) begin
      out_valid_d = 1'b1;
      out_sym_d   = sym_c;
      out_last_d  = tail_step_c && (tail_q == 4'd1);
      hist_d      = {hist_q[H_W-2:0], u_c};
      // Clear the whole history so a later, longer K starts from zero.
      if (tail_step_c && (tail_q == 4'd1)) hist_d = '0;
    end

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      hist_q      <= '0;
      k_q         <= 4'd3;
      g0_q        <= '0;
      g1_q        <= '0;
      tail_q      <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      hist_q      <= hist_d;
      k_q         <= k_d;
      g0_q        <= g0_d;
      g1_q        <= g1_d;
      tail_q      <= tail_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sym   = out_sym_q;
  assign bus.out_last  = out_last_q;
  assign busy_o        = busy_q;

`ifdef STATS_EN
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Count frames whose final tail symbol was taken downstream.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (out_valid_q && bus.out_ready && out_last_q) frame_cnt_d = CNT_W'(frame_cnt_q + 1'b1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) frame_cnt_q <= '0;
    else         frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt_o = frame_cnt_q;
`endif

endmodule
